// File: rtl/board_renderer.sv
// -----------------------------------------------------------------------------
// board_renderer
//
// Two-stage pixel pipeline that draws a COLS x ROWS game board (grid lines,
// round pieces, board background) into an incoming video timing stream. It
// also has a small write port that updates one board cell at a time. Each
// update is held until vertical blanking, so no visible pixel ever sees a
// half-written board.
//
// Ports
//   Clk, Reset              system clock, asynchronous active-low reset
//   Pix_En                  pixel tick; the pipeline advances only when high
//   Pix_X, Pix_Y            current pixel coordinate (Pix_Y 480..524 = vblank)
//   Pix_Valid               visible-area flag, delayed to Blank_Out
//   Hsync_In, Vsync_In      timing syncs, delayed to Hsync_Out / Vsync_Out
//   Wr_Req                  cell write request, held until Wr_Ack
//   Wr_Col, Wr_Row, Wr_Data target cell and 2-bit cell code
//   Wr_Ack, Wr_Err          one-clock completion pulse; Wr_Err marks rejection
//   Red, Green, Blue        rendered colour, 2 Pix_En ticks after the inputs
//   Hsync_Out, Vsync_Out    syncs delayed to line up with the colour
//   Blank_Out               delayed Pix_Valid (1 = visible)
// -----------------------------------------------------------------------------
module board_renderer #(
   parameter int BOARD_X0  = 40,
   parameter int CELL      = 80,
   parameter int COLS      = 7,
   parameter int ROWS      = 6,
   parameter int LINE_W    = 4,
   parameter int RADIUS_SQ = 1156
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Pix_En,
   input  logic [9:0] Pix_X,
   input  logic [9:0] Pix_Y,
   input  logic       Pix_Valid,
   input  logic       Hsync_In,
   input  logic       Vsync_In,
   input  logic       Wr_Req,
   input  logic [2:0] Wr_Col,
   input  logic [2:0] Wr_Row,
   input  logic [1:0] Wr_Data,
   output logic       Wr_Ack,
   output logic       Wr_Err,
   output logic [7:0] Red,
   output logic [7:0] Green,
   output logic [7:0] Blue,
   output logic       Hsync_Out,
   output logic       Vsync_Out,
   output logic       Blank_Out
);

   localparam int D_W      = $clog2(CELL);
   localparam int HALF     = CELL / 2;
   localparam int BOARD_X1 = BOARD_X0 + COLS * CELL;
   localparam int BOARD_Y1 = ROWS * CELL;
   localparam int N_CELLS  = COLS * ROWS;
   localparam int IDX_W    = $clog2(N_CELLS);
   localparam int VBLANK_Y = 480;

   typedef enum logic [1:0] {IDLE, WAIT_VB, COMMIT, ACK} wr_state_t;

   // ---------------------------------------------------------------------------
   // Board storage
   // ---------------------------------------------------------------------------
   logic [1:0]       board [N_CELLS];
   logic             commit_en;
   logic [2:0]       lat_col;
   logic [2:0]       lat_row;
   logic [1:0]       lat_data;
   logic             lat_err;
   logic [IDX_W-1:0] wr_idx;

   assign wr_idx = IDX_W'(int'(lat_row) * COLS + int'(lat_col));

   // NOTE: the cells must read as empty the instant Reset falls, so this array
   // is built from resettable flops rather than a RAM macro.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         for (int i = 0; i < N_CELLS; i++) board[i] <= 2'd0;
      end else if (commit_en) begin
         board[wr_idx] <= lat_data;
      end
   end

   // ---------------------------------------------------------------------------
   // Stage 1: locate the pixel on the board (compare chains, no divider)
   // ---------------------------------------------------------------------------
   logic [10:0]    x_ext, y_ext, x_base, y_base, x_off, y_off;
   logic [2:0]     c_col, c_row;
   logic [D_W-1:0] c_dx, c_dy;
   logic           c_in_board, c_grid;

   assign x_ext = {1'b0, Pix_X};
   assign y_ext = {1'b0, Pix_Y};

   // NOTE: every signal written here gets a default first, so no path through
   // the block can leave it unassigned and infer a latch.
   always_comb begin
      c_col  = '0;
      c_row  = '0;
      x_base = 11'(BOARD_X0);
      y_base = '0;
      // Each threshold passed bumps the index and the cell origin, so the
      // last match gives both the index and the cell's left/top edge.
      for (int k = 1; k < COLS; k++) begin
         if (x_ext >= 11'(BOARD_X0 + k * CELL)) begin
            c_col  = 3'(k);
            x_base = 11'(BOARD_X0 + k * CELL);
         end
      end
      for (int k = 1; k < ROWS; k++) begin
         if (y_ext >= 11'(k * CELL)) begin
            c_row  = 3'(k);
            y_base = 11'(k * CELL);
         end
      end
      // Left of the board this wraps, but in_board masks the result then.
      x_off      = x_ext - x_base;
      y_off      = y_ext - y_base;
      c_dx       = D_W'(x_off);
      c_dy       = D_W'(y_off);
      c_in_board = (x_ext >= 11'(BOARD_X0)) && (x_ext < 11'(BOARD_X1)) &&
                   (y_ext < 11'(BOARD_Y1));
      c_grid     = (c_dx < D_W'(LINE_W)) || (c_dy < D_W'(LINE_W));
   end

   logic           s1_in_board, s1_grid, s1_valid, s1_hs, s1_vs;
   logic [2:0]     s1_col, s1_row;
   logic [D_W-1:0] s1_dx, s1_dy;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the values from before the edge, whatever the block order.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         s1_in_board <= 1'b0;
         s1_grid     <= 1'b0;
         s1_valid    <= 1'b0;
         s1_hs       <= 1'b0;
         s1_vs       <= 1'b0;
         s1_col      <= '0;
         s1_row      <= '0;
         s1_dx       <= '0;
         s1_dy       <= '0;
      end else if (Pix_En) begin
         s1_in_board <= c_in_board;
         s1_grid     <= c_grid;
         s1_valid    <= Pix_Valid;
         s1_hs       <= Hsync_In;
         s1_vs       <= Vsync_In;
         s1_col      <= c_col;
         s1_row      <= c_row;
         s1_dx       <= c_dx;
         s1_dy       <= c_dy;
      end
   end

   // ---------------------------------------------------------------------------
   // Stage 2: cell lookup, piece circle test, colour select
   // ---------------------------------------------------------------------------
   logic [IDX_W-1:0] rd_idx;
   logic [1:0]       cell_code;
   logic [11:0]      ax, ay, dist_sq;
   logic             in_circle;
   logic [23:0]      cell_rgb, rgb_next;

   assign rd_idx    = IDX_W'(int'(s1_row) * COLS + int'(s1_col));
   assign cell_code = board[rd_idx];

   // The distance from the centre is squared as a magnitude. This gives the
   // same 12-bit result as squaring the wrapped signed difference.
   assign ax        = (s1_dx >= D_W'(HALF)) ? 12'(s1_dx) - 12'(HALF) : 12'(HALF) - 12'(s1_dx);
   assign ay        = (s1_dy >= D_W'(HALF)) ? 12'(s1_dy) - 12'(HALF) : 12'(HALF) - 12'(s1_dy);
   assign dist_sq   = ax * ax + ay * ay;
   assign in_circle = dist_sq < 12'(RADIUS_SQ);

   always_comb begin
      cell_rgb = 24'h202020;
      case (cell_code)
         2'd1:    cell_rgb = 24'hFF0000;
         2'd2:    cell_rgb = 24'hFFFF00;
         2'd3:    cell_rgb = 24'h00FF00;
         default: cell_rgb = 24'h202020;
      endcase
   end

   always_comb begin
      rgb_next = 24'h0000C0;
      if (!s1_valid || !s1_in_board) rgb_next = 24'h000000;
      else if (s1_grid)              rgb_next = 24'h660000;
      else if (in_circle)            rgb_next = cell_rgb;
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         Red       <= '0;
         Green     <= '0;
         Blue      <= '0;
         Hsync_Out <= 1'b0;
         Vsync_Out <= 1'b0;
         Blank_Out <= 1'b0;
      end else if (Pix_En) begin
         Red       <= rgb_next[23:16];
         Green     <= rgb_next[15:8];
         Blue      <= rgb_next[7:0];
         Hsync_Out <= s1_hs;
         Vsync_Out <= s1_vs;
         Blank_Out <= s1_valid;
      end
   end

   // ---------------------------------------------------------------------------
   // Write FSM: latch request, wait for vblank, commit, acknowledge
   // ---------------------------------------------------------------------------
   wr_state_t state, state_next;
   logic      latch_en, req_ok;

   assign req_ok = ({1'b0, Wr_Col} < 4'(COLS)) && ({1'b0, Wr_Row} < 4'(ROWS));

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      latch_en   = 1'b0;
      commit_en  = 1'b0;
      Wr_Ack     = 1'b0;
      Wr_Err     = 1'b0;
      case (state)
         IDLE: begin
            if (Wr_Req) begin
               latch_en   = 1'b1;
               state_next = req_ok ? WAIT_VB : ACK;
            end
         end
         WAIT_VB: begin
            // Pix_Y is already in blanking here, so the pixel for this tick
            // is not visible and a commit on the next clock is safe.
            if (Pix_En && (Pix_Y >= 10'(VBLANK_Y))) state_next = COMMIT;
         end
         COMMIT: begin
            commit_en  = 1'b1;
            state_next = ACK;
         end
         ACK: begin
            Wr_Ack     = 1'b1;
            Wr_Err     = lat_err;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         lat_col  <= '0;
         lat_row  <= '0;
         lat_data <= '0;
         lat_err  <= 1'b0;
      end else if (latch_en) begin
         lat_col  <= Wr_Col;
         lat_row  <= Wr_Row;
         lat_data <= Wr_Data;
         lat_err  <= ~req_ok;
      end
   end

endmodule
